// File: rtl/pipe_line_mips.sv
// Five-stage 32-bit MIPS subset core (IF, ID, EX, MEM, WB) with EX forwarding,
// load-use interlock and branch/jump resolution in ID (one-cycle taken penalty).

module pipe_line_mips_imem #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);
    // Program storage only; contents are placed here from outside before reset release.
    logic [31:0] imem [WORDS];

    assign rdata_o = imem[raddr_i];
endmodule

module pipe_line_mips_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_o
);
    logic [31:0] PC;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) PC <= '0;
        else      PC <= pc_d_i;
    end

    assign pc_o = PC;
endmodule

module pipe_line_mips #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return (sa < sb) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic dst_hit(input logic we, input logic [4:0] dst,
                                     input logic [4:0] src);
        return we && (dst != 5'd0) && (dst == src);
    endfunction

    logic [31:0] pc, pc_d, pc_plus4, instrIF;

    logic [31:0] ifid_instr_q, ifid_pc4_q;

    logic        idex_we_q, idex_lw_q, idex_sw_q, idex_imm_sel_q;
    alu_op_e     idex_alu_q;
    logic [4:0]  idex_rd_q, idex_rs_q, idex_rt_q;
    logic [31:0] idex_a_q, idex_b_q, idex_imm_q;

    logic        exmem_we_q, exmem_lw_q, exmem_sw_q;
    logic [4:0]  exmem_rd_q;
    logic [31:0] exmem_alu_q, exmem_st_q;

    logic        memwb_we_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_val_q;

    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [DMEM_WORDS];

    // ---------------- IF ----------------
    pipe_line_mips_pc P_PC (
        .clk    (clk),
        .rst    (rst),
        .pc_d_i (pc_d),
        .pc_o   (pc)
    );

    pipe_line_mips_imem #(.WORDS(IMEM_WORDS)) P_IM (
        .raddr_i (pc[IAW+1:2]),
        .rdata_o (instrIF)
    );

    assign pc_plus4 = pc + 32'd4;

    // ---------------- ID ----------------
    logic [5:0]  id_op, id_fn;
    logic [4:0]  id_rs, id_rt, id_rd, id_dst;
    logic [31:0] id_imm, id_rs_val, id_rt_val, br_a, br_b, redirect_pc;
    logic        id_we, id_lw, id_sw, id_beq, id_j, id_imm_sel, id_use_rs, id_use_rt;
    logic        load_use, br_stall, stall, redirect;
    alu_op_e     id_alu;

    assign id_op  = ifid_instr_q[31:26];
    assign id_rs  = ifid_instr_q[25:21];
    assign id_rt  = ifid_instr_q[20:16];
    assign id_rd  = ifid_instr_q[15:11];
    assign id_fn  = ifid_instr_q[5:0];
    assign id_imm = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

    always_comb begin
        id_we = 1'b0; id_lw = 1'b0; id_sw = 1'b0; id_beq = 1'b0; id_j = 1'b0;
        id_imm_sel = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_dst = id_rd;
        id_alu = ALU_ADD;
        case (id_op)
            OP_RTYPE: begin
                id_we = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1;
                case (id_fn)
                    FN_ADD:  id_alu = ALU_ADD;
                    FN_SUB:  id_alu = ALU_SUB;
                    FN_AND:  id_alu = ALU_AND;
                    FN_OR:   id_alu = ALU_OR;
                    FN_SLT:  id_alu = ALU_SLT;
                    default: begin id_we = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; end
                endcase
            end
            OP_ADDI: begin id_we = 1'b1; id_use_rs = 1'b1; id_imm_sel = 1'b1; id_dst = id_rt; end
            OP_LW: begin
                id_we = 1'b1; id_lw = 1'b1; id_use_rs = 1'b1; id_imm_sel = 1'b1; id_dst = id_rt;
            end
            OP_SW:   begin id_sw = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1; id_imm_sel = 1'b1; end
            OP_BEQ:  begin id_beq = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1; end
            OP_J:    id_j = 1'b1;
            default: ;
        endcase
    end

    // Register read sees the value being written back in this same cycle.
    always_comb begin
        id_rs_val = rf_q[id_rs];
        id_rt_val = rf_q[id_rt];
        if (dst_hit(memwb_we_q, memwb_rd_q, id_rs)) id_rs_val = memwb_val_q;
        if (dst_hit(memwb_we_q, memwb_rd_q, id_rt)) id_rt_val = memwb_val_q;
        if (id_rs == 5'd0) id_rs_val = '0;
        if (id_rt == 5'd0) id_rt_val = '0;
    end

    assign br_a = dst_hit(exmem_we_q && !exmem_lw_q, exmem_rd_q, id_rs) ? exmem_alu_q : id_rs_val;
    assign br_b = dst_hit(exmem_we_q && !exmem_lw_q, exmem_rd_q, id_rt) ? exmem_alu_q : id_rt_val;

    assign load_use = idex_lw_q && ((id_use_rs && dst_hit(1'b1, idex_rd_q, id_rs)) ||
                                    (id_use_rt && dst_hit(1'b1, idex_rd_q, id_rt)));
    // beq compares in ID: results still in EX, or load data not yet read, are not available.
    assign br_stall = id_beq && (dst_hit(idex_we_q, idex_rd_q, id_rs) ||
                                 dst_hit(idex_we_q, idex_rd_q, id_rt) ||
                                 dst_hit(exmem_lw_q, exmem_rd_q, id_rs) ||
                                 dst_hit(exmem_lw_q, exmem_rd_q, id_rt));
    assign stall    = load_use || br_stall;
    assign redirect = !stall && (id_j || (id_beq && (br_a == br_b)));

    assign redirect_pc = id_j ? {ifid_pc4_q[31:28], ifid_instr_q[25:0], 2'b00}
                              : ifid_pc4_q + {id_imm[29:0], 2'b00};
    assign pc_d = stall ? pc : (redirect ? redirect_pc : pc_plus4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
        end else if (!stall) begin
            ifid_instr_q <= redirect ? 32'd0 : instrIF;
            ifid_pc4_q   <= pc_plus4;
        end
    end

    // ---------------- ID/EX ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_we_q <= 1'b0; idex_lw_q <= 1'b0; idex_sw_q <= 1'b0; idex_imm_sel_q <= 1'b0;
            idex_alu_q <= ALU_ADD;
            idex_rd_q <= '0; idex_rs_q <= '0; idex_rt_q <= '0;
            idex_a_q <= '0; idex_b_q <= '0; idex_imm_q <= '0;
        end else begin
            idex_we_q      <= id_we && !stall;
            idex_lw_q      <= id_lw && !stall;
            idex_sw_q      <= id_sw && !stall;
            idex_imm_sel_q <= id_imm_sel;
            idex_alu_q     <= id_alu;
            idex_rd_q      <= id_dst;
            idex_rs_q      <= id_rs;
            idex_rt_q      <= id_rt;
            idex_a_q       <= id_rs_val;
            idex_b_q       <= id_rt_val;
            idex_imm_q     <= id_imm;
        end
    end

    // ---------------- EX ----------------
    logic [31:0] ex_a, ex_b;

    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (dst_hit(exmem_we_q, exmem_rd_q, idex_rs_q))      ex_a = exmem_alu_q;
        else if (dst_hit(memwb_we_q, memwb_rd_q, idex_rs_q)) ex_a = memwb_val_q;
        if (dst_hit(exmem_we_q, exmem_rd_q, idex_rt_q))      ex_b = exmem_alu_q;
        else if (dst_hit(memwb_we_q, memwb_rd_q, idex_rt_q)) ex_b = memwb_val_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_we_q <= 1'b0; exmem_lw_q <= 1'b0; exmem_sw_q <= 1'b0;
            exmem_rd_q <= '0; exmem_alu_q <= '0; exmem_st_q <= '0;
        end else begin
            exmem_we_q  <= idex_we_q;
            exmem_lw_q  <= idex_lw_q;
            exmem_sw_q  <= idex_sw_q;
            exmem_rd_q  <= idex_rd_q;
            exmem_alu_q <= alu(idex_alu_q, ex_a, idex_imm_sel_q ? idex_imm_q : ex_b);
            exmem_st_q  <= ex_b;
        end
    end

    // ---------------- MEM ----------------
    logic [31:0] mem_rdata;
    assign mem_rdata = dmem_q[exmem_alu_q[DAW+1:2]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
        end else if (exmem_sw_q) begin
            dmem_q[exmem_alu_q[DAW+1:2]] <= exmem_st_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_we_q <= 1'b0; memwb_rd_q <= '0; memwb_val_q <= '0;
        end else begin
            memwb_we_q  <= exmem_we_q;
            memwb_rd_q  <= exmem_rd_q;
            memwb_val_q <= exmem_lw_q ? mem_rdata : exmem_alu_q;
        end
    end

    // ---------------- WB ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (memwb_we_q && memwb_rd_q != 5'd0) begin
            rf_q[memwb_rd_q] <= memwb_val_q;
        end
    end
endmodule

// File: tb/tb_pipe_line_mips.sv
// Bench for pipe_line_mips: directed pipeline-timing programs plus random
// programs checked against an instruction-level interpreter.

module tb_pipe_line_mips;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pipe_line_mips #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] prog [256];
    logic [31:0] m_rf [32];
    logic [31:0] m_dm [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    function automatic int rreg();
        return int'($urandom_range(0, 7));
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'd0;
    endtask

    // Instruction-level interpreter: runs until the jump-to-self terminator.
    task automatic model_run();
        logic [31:0] pc, nxt, w, a, b, imm, addr;
        logic [4:0]  rt, rd;
        for (int i = 0; i < 32; i++)  m_rf[i] = 32'd0;
        for (int i = 0; i < 256; i++) m_dm[i] = 32'd0;
        pc = 32'd0;
        for (int steps = 0; steps < 2000; steps++) begin
            w   = prog[pc[9:2]];
            nxt = pc + 32'd4;
            if (w[31:26] == 6'h02 && {nxt[31:28], w[25:0], 2'b00} == pc) break;
            a    = m_rf[w[25:21]];
            b    = m_rf[w[20:16]];
            rt   = w[20:16];
            rd   = w[15:11];
            imm  = {{16{w[15]}}, w[15:0]};
            addr = a + imm;
            case (w[31:26])
                6'h00: begin
                    case (w[5:0])
                        6'h20: m_rf[rd] = a + b;
                        6'h22: m_rf[rd] = a - b;
                        6'h24: m_rf[rd] = a & b;
                        6'h25: m_rf[rd] = a | b;
                        6'h2A: m_rf[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: ;
                    endcase
                end
                6'h08: m_rf[rt] = a + imm;
                6'h23: m_rf[rt] = m_dm[addr[9:2]];
                6'h2B: m_dm[addr[9:2]] = b;
                6'h04: if (a == b) nxt = pc + 32'd4 + (imm << 2);
                6'h02: nxt = {nxt[31:28], w[25:0], 2'b00};
                default: ;
            endcase
            m_rf[0] = 32'd0;
            pc = nxt;
        end
    endtask

    task automatic cmp_state(input string tag);
        for (int r = 1; r < 32; r++)
            chk($sformatf("%s reg%0d", tag, r), dut.rf_q[r], m_rf[r]);
        for (int i = 0; i < 256; i++)
            chk($sformatf("%s dmem%0d", tag, i), dut.dmem_q[i], m_dm[i]);
    endtask

    // Asynchronous reset mid-cycle, load program, hold two edges, release.
    task automatic start(input string tag);
        #2 rst = 1'b0;
        #1 chk({tag, " async rst pc"}, dut.P_PC.PC, 32'd0);
        for (int i = 0; i < 256; i++) dut.P_IM.imem[i] = prog[i];
        @(posedge clk);
        @(posedge clk);
        #1;
        chk({tag, " rst pc"}, dut.P_PC.PC, 32'd0);
        chk({tag, " rst instrIF"}, dut.instrIF, prog[0]);
        for (int r = 1; r < 8; r++) chk($sformatf("%s rst reg%0d", tag, r), dut.rf_q[r], 32'd0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s rst dmem%0d", tag, i), dut.dmem_q[i], 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk({tag, " release pc"}, dut.P_PC.PC, 32'd0);
    endtask

    task automatic step_pc(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1 chk(tag, dut.P_PC.PC, exp);
    endtask

    task automatic finish_prog(input string tag, input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        model_run();
        cmp_state(tag);
    endtask

    task automatic gen_prog();
        int L, k, lim, b;
        logic [31:0] tmp;
        logic [5:0] fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        clear_prog();
        L = int'($urandom_range(16, 28));
        for (int i = 0; i < L; i++) begin
            k   = int'($urandom_range(0, 11));
            tmp = $urandom;
            b   = ($urandom_range(0, 1) == 1) ? 0 : rreg();
            case (k)
                0, 1:    prog[i] = enc_i(6'h08, rreg(), rreg(), tmp[15:0]);
                2, 3, 4: prog[i] = enc_r(rreg(), rreg(), rreg(), fns[$urandom_range(0, 4)]);
                5:       prog[i] = enc_i(6'h23, b, rreg(), {10'd0, tmp[3:0], 2'b00});
                6:       prog[i] = enc_i(6'h2B, b, rreg(), {10'd0, tmp[3:0], 2'b00});
                7: begin
                    lim = (L - 1 - i < 3) ? L - 1 - i : 3;
                    prog[i] = enc_i(6'h04, rreg(), rreg(), 16'($urandom_range(0, lim)));
                end
                8:       prog[i] = enc_j(26'($urandom_range(i + 1, L)));
                9:       prog[i] = 32'd0;
                10:      prog[i] = {6'h0D, tmp[25:0]};
                default: prog[i] = enc_r(rreg(), rreg(), rreg(), 6'h26);
            endcase
        end
        prog[L] = enc_j(26'(L));
    endtask

    initial begin
        // forwarding chain, no stalls
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog[1] = enc_i(6'h08, 1, 2, 16'd3);
        prog[2] = enc_r(1, 2, 3, 6'h20);
        prog[3] = enc_j(26'd3);
        start("fwd");
        for (int k = 1; k <= 4; k++) step_pc($sformatf("fwd pc edge%0d", k), 32'(4 * k));
        finish_prog("fwd", 20);
        chk("fwd r3 const", dut.rf_q[3], 32'd13);

        // store then load-use
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 3, 16'd13);
        prog[1] = enc_i(6'h2B, 0, 3, 16'd4);
        prog[2] = enc_i(6'h23, 0, 4, 16'd4);
        prog[3] = enc_r(4, 4, 5, 6'h20);
        prog[4] = enc_j(26'd4);
        start("lu");
        step_pc("lu pc edge1", 32'h04);
        step_pc("lu pc edge2", 32'h08);
        step_pc("lu pc edge3", 32'h0C);
        step_pc("lu pc edge4", 32'h10);
        step_pc("lu pc edge5 held", 32'h10);
        step_pc("lu pc edge6", 32'h14);
        finish_prog("lu", 20);
        chk("lu dmem1 const", dut.dmem_q[1], 32'd13);
        chk("lu r5 const", dut.rf_q[5], 32'd26);

        // taken beq: squash 0x14, skip 0x18
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'd1);
        prog[4] = enc_i(6'h04, 0, 0, 16'd2);
        prog[5] = enc_i(6'h08, 0, 7, 16'd9);
        prog[6] = enc_i(6'h08, 0, 6, 16'd8);
        prog[7] = enc_i(6'h08, 0, 2, 16'd4);
        prog[8] = enc_j(26'd8);
        start("beqT");
        for (int k = 1; k <= 5; k++) step_pc($sformatf("beqT pc edge%0d", k), 32'(4 * k));
        step_pc("beqT pc target", 32'h1C);
        finish_prog("beqT", 20);
        chk("beqT r7 squashed", dut.rf_q[7], 32'd0);
        chk("beqT r2 const", dut.rf_q[2], 32'd4);

        // not-taken beq, no penalty
        clear_prog();
        prog[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog[4] = enc_i(6'h04, 1, 0, 16'd2);
        prog[5] = enc_i(6'h08, 0, 2, 16'd4);
        prog[6] = enc_j(26'd6);
        start("beqN");
        for (int k = 1; k <= 7; k++) step_pc($sformatf("beqN pc edge%0d", k), 32'(4 * k));
        finish_prog("beqN", 20);
        chk("beqN r2 const", dut.rf_q[2], 32'd4);

        // jump and $0 hardwiring
        clear_prog();
        prog[0]  = enc_j(26'h10);
        prog[1]  = enc_i(6'h08, 0, 7, 16'd1);
        prog[16] = enc_i(6'h08, 0, 6, 16'd9);
        prog[17] = enc_i(6'h08, 0, 0, 16'd7);
        prog[18] = enc_r(0, 0, 6, 6'h20);
        prog[19] = enc_j(26'd19);
        start("jmp");
        step_pc("jmp pc edge1", 32'h04);
        step_pc("jmp pc target", 32'h40);
        finish_prog("jmp", 20);
        chk("jmp r6 const", dut.rf_q[6], 32'd0);
        chk("jmp r7 squashed", dut.rf_q[7], 32'd0);

        for (int t = 0; t < 20; t++) begin
            gen_prog();
            start($sformatf("rnd%0d", t));
            finish_prog($sformatf("rnd%0d", t), 130);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
